apb_cmd_master: RTL

- Command-queue-driven APB requester; sits directly upstream of apb_slave and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA.
- Buffers read/write commands from a local valid/ready interface and issues them as standard two-phase APB transfers (SETUP then ACCESS).
- Honours PREADY wait states, enforces a wait-state timeout, and returns one response per transfer (read data, error flags) on a valid/ready response port.

---
 rtl/apb_cmd_master.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master
//   Command-queue-driven APB requester. Commands arrive on a valid/ready port
//   and are buffered in a small FIFO. Each one is issued as a two-phase APB
//   transfer (SETUP, then ACCESS). ACCESS is held through PREADY wait states,
//   with an optional wait-state timeout. One response per transfer is returned
//   on a valid/ready response port.
//
// Ports
//   PCLK, PRESET       clock (rising edge), synchronous active-high reset
//   cmd_valid/ready    command handshake; cmd_ready is !full and comes from registers only
//   cmd_write/addr/wdata  command payload (wdata ignored for reads)
//   resp_valid/ready   response handshake
//   resp_write         direction of the completed transfer
//   resp_rdata         PRDATA for reads; 0 for writes and timeouts
//   resp_err           PSLVERR at completion, or 1 on timeout
//   resp_timeout       transfer aborted by the wait-state timeout
//   busy               FSM not idle or queue not empty
//   PSEL..PWDATA       registered APB request outputs
//   PRDATA/PREADY/PSLVERR  APB completer inputs

module apb_cmd_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,

  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,

  output logic                  busy,

  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  // Counter only has to reach TIMEOUT-1.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PtrW:0] FullCount = (PtrW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_write_q;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;

  logic full, empty, push, pop;

  assign full      = (count_q == FullCount);
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PtrW + 1)'(1);
      2'b01:   count_d = count_q - (PtrW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q]  <= cmd_addr;
      fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
      fifo_write_q[wr_ptr_q] <= cmd_write;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer FSM and response register
  // ---------------------------------------------------------------------------
  state_e state_q, state_d;

  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_write_q, resp_write_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  resp_err_q, resp_err_d;
  logic                  resp_timeout_q, resp_timeout_d;

  logic slot_free;

  // Issue only when the response can be parked, so a completed transfer never
  // overwrites one that has not been consumed.
  assign slot_free = !resp_valid_q || resp_ready;

  always_comb begin
    state_d        = state_q;
    psel_d         = psel_q;
    penable_d      = penable_q;
    pwrite_d       = pwrite_q;
    paddr_d        = paddr_q;
    pwdata_d       = pwdata_q;
    cnt_d          = cnt_q;
    resp_valid_d   = resp_valid_q;
    resp_write_d   = resp_write_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;
    resp_timeout_d = resp_timeout_q;
    pop            = 1'b0;

    // Consumption first; a completion below on the same edge overrides it.
    if (resp_valid_q && resp_ready) begin
      resp_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (!empty && slot_free) begin
          pop       = 1'b1;
          paddr_d   = fifo_addr_q[rd_ptr_q];
          pwdata_d  = fifo_wdata_q[rd_ptr_q];
          pwrite_d  = fifo_write_q[rd_ptr_q];
          psel_d    = 1'b1;
          state_d   = StSetup;
        end
      end

      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = StAccess;
      end

      StAccess: begin
        if (PREADY) begin
          resp_valid_d   = 1'b1;
          resp_write_d   = pwrite_q;
          resp_rdata_d   = pwrite_q ? '0 : PRDATA;
          resp_err_d     = PSLVERR;
          resp_timeout_d = 1'b0;
          psel_d         = 1'b0;
          penable_d      = 1'b0;
          state_d        = StIdle;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          // cnt_q counts completed wait cycles, so the abort lands on the
          // TIMEOUT-th ACCESS cycle.
          if ((TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1))) begin
            resp_valid_d   = 1'b1;
            resp_write_d   = pwrite_q;
            resp_rdata_d   = '0;
            resp_err_d     = 1'b1;
            resp_timeout_d = 1'b1;
            psel_d         = 1'b0;
            penable_d      = 1'b0;
            state_d        = StIdle;
          end
        end
      end

      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q        <= StIdle;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      pwrite_q       <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_write_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
      resp_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      pwrite_q       <= pwrite_d;
      paddr_q        <= paddr_d;
      pwdata_q       <= pwdata_d;
      cnt_q          <= cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_write_q   <= resp_write_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
      resp_timeout_q <= resp_timeout_d;
    end
  end

  assign PSEL         = psel_q;
  assign PENABLE      = penable_q;
  assign PWRITE       = pwrite_q;
  assign PADDR        = paddr_q;
  assign PWDATA       = pwdata_q;

  assign resp_valid   = resp_valid_q;
  assign resp_write   = resp_write_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign resp_timeout = resp_timeout_q;

  assign busy         = (state_q != StIdle) || !empty;

endmodule
